// File: rtl/zap_cache_line_fill_pkg.sv
// Shared constants for the cache line-fill engine: Wishbone cycle types, FSM encodings
// and the beat-address helper.
package zap_cache_line_fill_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_BURST   = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [15:0] BEN_FULL = 16'hFFFF;

  // Beats stay inside the 16-byte line, so only the word-select bits change.
  function automatic logic [31:0] beat_adr(input logic [27:0] line_adr, input logic [1:0] beat);
    return {line_adr, beat, 2'b00};
  endfunction

endpackage

// File: rtl/zap_cache_line_fill.sv
// Cache line-fill engine: 4-beat incrementing Wishbone burst read of one 16-byte line,
// followed by a single-cycle full-line commit to the tag/data RAM write port.
module zap_cache_line_fill
  import zap_cache_line_fill_pkg::*;
#(
  parameter int unsigned TAG_WDT    = 28,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_fill_req,
  input  logic [31:0]        i_fill_pa,
  output logic               o_fill_busy,
  output logic               o_fill_done,
  output logic               o_fill_err,
  output logic [127:0]       o_cache_line,
  output logic [15:0]        o_cache_line_ben,
  output logic               o_cache_tag_wr_en,
  output logic [TAG_WDT-1:0] o_cache_tag,
  output logic               o_cache_tag_dirty,
  output logic               o_wb_cyc,
  output logic               o_wb_stb,
  output logic [31:0]        o_wb_adr,
  output logic [3:0]         o_wb_sel,
  output logic               o_wb_wen,
  output logic [2:0]         o_wb_cti,
  input  logic               i_wb_ack,
  input  logic               i_wb_err,
  input  logic [31:0]        i_wb_dat
);

  localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);

  logic [1:0]  state;
  logic [1:0]  beat;
  logic [1:0]  next_beat;
  logic [27:0] line_adr;
  logic        beat_ok;
  logic        beat_err;
  logic        unused_pa;

  assign unused_pa = ^i_fill_pa[3:0];
  assign next_beat = beat + 2'd1;
  // err wins over a simultaneous ack.
  assign beat_err  = o_wb_stb & i_wb_err;
  assign beat_ok   = o_wb_stb & i_wb_ack & ~i_wb_err;

  assign o_wb_sel          = 4'hF;
  assign o_wb_wen          = 1'b0;
  assign o_cache_tag_dirty = 1'b0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state             <= ST_IDLE;
      beat              <= 2'd0;
      line_adr          <= '0;
      o_fill_busy       <= 1'b0;
      o_fill_done       <= 1'b0;
      o_fill_err        <= 1'b0;
      o_cache_line      <= '0;
      o_cache_line_ben  <= '0;
      o_cache_tag_wr_en <= 1'b0;
      o_cache_tag       <= '0;
      o_wb_cyc          <= 1'b0;
      o_wb_stb          <= 1'b0;
      o_wb_adr          <= '0;
      o_wb_cti          <= CTI_CLASSIC;
    end else begin
      o_fill_done       <= 1'b0;
      o_fill_err        <= 1'b0;
      o_cache_tag_wr_en <= 1'b0;
      o_cache_line_ben  <= '0;
      case (state)
        ST_IDLE: begin
          if (i_fill_req) begin
            state        <= ST_FILL;
            beat         <= 2'd0;
            line_adr     <= i_fill_pa[31:4];
            o_cache_tag  <= i_fill_pa[31 -: TAG_WDT];
            o_cache_line <= '0;
            o_fill_busy  <= 1'b1;
            o_wb_cyc     <= 1'b1;
            o_wb_stb     <= 1'b1;
            o_wb_adr     <= beat_adr(i_fill_pa[31:4], 2'd0);
            o_wb_cti     <= CTI_BURST;
          end
        end
        ST_FILL: begin
          if (beat_err) begin
            state        <= ST_ERR;
            beat         <= 2'd0;
            o_cache_line <= '0;
            o_fill_err   <= 1'b1;
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_cti     <= CTI_CLASSIC;
          end else if (beat_ok) begin
            o_cache_line[{beat, 5'd0} +: 32] <= i_wb_dat;
            if (beat == LAST_BEAT) begin
              state             <= ST_COMMIT;
              beat              <= 2'd0;
              o_fill_done       <= 1'b1;
              o_cache_tag_wr_en <= 1'b1;
              o_cache_line_ben  <= BEN_FULL;
              o_wb_cyc          <= 1'b0;
              o_wb_stb          <= 1'b0;
              o_wb_cti          <= CTI_CLASSIC;
            end else begin
              beat     <= next_beat;
              o_wb_adr <= beat_adr(line_adr, next_beat);
              o_wb_cti <= (next_beat == LAST_BEAT) ? CTI_EOB : CTI_BURST;
            end
          end
        end
        ST_COMMIT, ST_ERR: begin
          // Requests seen in this exit cycle are deliberately not accepted.
          state       <= ST_IDLE;
          o_fill_busy <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          o_fill_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
